// File: rtl/fpga_config_loader.sv
// Configuration loader: hunts for the FA B0 sync word, then shifts each frame LSB-first into the
// frame-data register and writes it with a strobe/increment pair. CONFIG_LOADER_CHK_EN adds an XOR trailer check.
module fpga_config_loader #(
   parameter int FRAME_BITS = 192,
   parameter int NUM_FRAMES = 288
) (
   input  logic       config_clk,
   input  logic       config_rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       fd_shift,
   output logic       fd_data,
   output logic       rs_reset,
   output logic       rs_incr,
   output logic       rs_strobe,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int BYTES_PER_FRAME = FRAME_BITS / 8;
   localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam int BYTE_W  = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;
   localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
   localparam logic [BYTE_W-1:0]  LAST_BYTE  = BYTE_W'(BYTES_PER_FRAME - 1);

`ifdef CONFIG_LOADER_CHK_EN
   typedef enum logic [2:0] {
      S_HUNT = 3'd0, S_CLR = 3'd1, S_LOAD = 3'd2, S_SHIFT = 3'd3,
      S_STROBE = 3'd4, S_INCR = 3'd5, S_CHK = 3'd6
   } state_t;
`else
   typedef enum logic [2:0] {
      S_HUNT = 3'd0, S_CLR = 3'd1, S_LOAD = 3'd2, S_SHIFT = 3'd3,
      S_STROBE = 3'd4, S_INCR = 3'd5
   } state_t;
`endif

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_accept;
   logic                w_sync;
   logic                w_last_bit;
   logic                w_last_byte;
   logic                w_last_frame;
   logic                w_complete;
   logic                r_in_ready;
   logic                r_fd_shift;
   logic                r_fd_data;
   logic                r_rs_reset;
   logic                r_rs_incr;
   logic                r_rs_strobe;
   logic                r_busy;
   logic                r_done;
   logic                r_seen_fa;
   logic [7:0]          r_byte;
   logic [2:0]          r_bit_cnt;
   logic [BYTE_W-1:0]   r_byte_cnt;
   logic [FRAME_W-1:0]  r_frame_cnt;
`ifdef CONFIG_LOADER_CHK_EN
   logic [7:0]          r_acc;
   logic                r_err;
`endif

   // States in which the upstream byte stream may hand over a byte.
   function automatic logic accepts_bytes(input state_t s);
      case (s)
         S_HUNT, S_LOAD: accepts_bytes = 1'b1;
`ifdef CONFIG_LOADER_CHK_EN
         S_CHK:          accepts_bytes = 1'b1;
`endif
         default:        accepts_bytes = 1'b0;
      endcase
   endfunction

   assign w_accept     = in_valid & r_in_ready;
   assign w_sync       = (r_state == S_HUNT) & w_accept & r_seen_fa & (in_data == 8'hB0);
   assign w_last_bit   = (r_bit_cnt == 3'd7);
   assign w_last_byte  = (r_byte_cnt == LAST_BYTE);
   assign w_last_frame = (r_frame_cnt == LAST_FRAME);

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      w_complete  = 1'b0;
      case (r_state)
         S_HUNT: begin
            if (w_sync) w_state_nxt = S_CLR;
            else        w_state_nxt = S_HUNT;
         end
         S_CLR: w_state_nxt = S_LOAD;
         S_LOAD: begin
            if (w_accept) w_state_nxt = S_SHIFT;
            else          w_state_nxt = S_LOAD;
         end
         S_SHIFT: begin
            if (!w_last_bit)     w_state_nxt = S_SHIFT;
            else if (w_last_byte) w_state_nxt = S_STROBE;
            else                 w_state_nxt = S_LOAD;
         end
         S_STROBE: w_state_nxt = S_INCR;
         S_INCR: begin
            if (!w_last_frame) begin
               w_state_nxt = S_LOAD;
            end else begin
`ifdef CONFIG_LOADER_CHK_EN
               w_state_nxt = S_CHK;
`else
               w_state_nxt = S_HUNT;
               w_complete  = 1'b1;
`endif
            end
         end
`ifdef CONFIG_LOADER_CHK_EN
         S_CHK: begin
            if (w_accept) begin
               w_state_nxt = S_HUNT;
               w_complete  = 1'b1;
            end else begin
               w_state_nxt = S_CHK;
            end
         end
`endif
         default: w_state_nxt = S_HUNT;
      endcase
   end

   // State register; strobes are decoded from the next state so they are flop outputs.
   always_ff @(posedge config_clk or negedge config_rst_n) begin
      if (!config_rst_n) begin
         r_state     <= S_HUNT;
         r_in_ready  <= 1'b0;
         r_fd_shift  <= 1'b0;
         r_rs_reset  <= 1'b0;
         r_rs_strobe <= 1'b0;
         r_rs_incr   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= accepts_bytes(w_state_nxt);
         r_fd_shift  <= (w_state_nxt == S_SHIFT);
         r_rs_reset  <= (w_state_nxt == S_CLR);
         r_rs_strobe <= (w_state_nxt == S_STROBE);
         r_rs_incr   <= (w_state_nxt == S_INCR);
      end
   end

   // Sync tracking, counters, serialiser and completion status.
   always_ff @(posedge config_clk or negedge config_rst_n) begin
      if (!config_rst_n) begin
         r_seen_fa   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_byte      <= 8'd0;
         r_fd_data   <= 1'b0;
         r_bit_cnt   <= 3'd0;
         r_byte_cnt  <= '0;
         r_frame_cnt <= '0;
`ifdef CONFIG_LOADER_CHK_EN
         r_acc       <= 8'd0;
         r_err       <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_HUNT: begin
               if (w_sync) begin
                  r_seen_fa   <= 1'b0;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_bit_cnt   <= 3'd0;
                  r_byte_cnt  <= '0;
                  r_frame_cnt <= '0;
`ifdef CONFIG_LOADER_CHK_EN
                  r_acc       <= 8'd0;
                  r_err       <= 1'b0;
`endif
               end else if (w_accept) begin
                  // A stray FA re-arms the search rather than being lost.
                  r_seen_fa <= (in_data == 8'hFA);
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_byte    <= in_data;
                  r_fd_data <= in_data[0];
                  r_bit_cnt <= 3'd0;
`ifdef CONFIG_LOADER_CHK_EN
                  r_acc     <= r_acc ^ in_data;
`endif
               end
            end
            S_SHIFT: begin
               if (w_last_bit) begin
                  r_bit_cnt  <= 3'd0;
                  r_fd_data  <= 1'b0;
                  r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + BYTE_W'(1);
               end else begin
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  r_fd_data <= r_byte[r_bit_cnt + 3'd1];
               end
            end
            S_INCR: begin
               r_frame_cnt <= w_last_frame ? '0 : r_frame_cnt + FRAME_W'(1);
               if (w_complete) begin
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
               end
            end
`ifdef CONFIG_LOADER_CHK_EN
            S_CHK: begin
               if (w_accept) begin
                  r_err  <= (in_data != r_acc);
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
               end
            end
`endif
            default: begin
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign fd_shift  = r_fd_shift;
   assign fd_data   = r_fd_data;
   assign rs_reset  = r_rs_reset;
   assign rs_incr   = r_rs_incr;
   assign rs_strobe = r_rs_strobe;
   assign busy      = r_busy;
   assign done      = r_done;
`ifdef CONFIG_LOADER_CHK_EN
   assign err       = r_err;
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_config_loader.sv
// Scoreboard bench for fpga_config_loader: a small instance (16-bit frames, 3 frames) for protocol
// corner cases and a default-parameter instance for a full-length stream.
module tb_fpga_config_loader;

   localparam int FB = 16;
   localparam int NF = 3;
   localparam logic [7:0] EV_RESET  = 8'h10;
   localparam logic [7:0] EV_STROBE = 8'h20;
   localparam logic [7:0] EV_INCR   = 8'h30;
   localparam logic [7:0] EV_NONE   = 8'hFF;
   localparam logic [7:0] EV_EMPTY  = 8'hEE;

   logic       config_clk = 1'b0;
   logic       config_rst_n = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       in_valid = 1'b0;
   logic       in_ready, fd_shift, fd_data, rs_reset, rs_incr, rs_strobe, busy, done, err;

   logic [7:0] b_in_data = 8'd0;
   logic       b_in_valid = 1'b0;
   logic       b_in_ready, b_fd_shift, b_fd_data, b_rs_reset, b_rs_incr, b_rs_strobe, b_busy, b_done, b_err;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] sb_q[$];
   logic [7:0] mon_code;
   int         big_shift = 0;
   int         big_strobes = 0;

   always #5 config_clk = ~config_clk;

   fpga_config_loader #(.FRAME_BITS(FB), .NUM_FRAMES(NF)) u_dut (
      .config_clk(config_clk), .config_rst_n(config_rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .fd_shift(fd_shift), .fd_data(fd_data), .rs_reset(rs_reset),
      .rs_incr(rs_incr), .rs_strobe(rs_strobe), .busy(busy), .done(done), .err(err)
   );

   fpga_config_loader u_big (
      .config_clk(config_clk), .config_rst_n(config_rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .fd_shift(b_fd_shift), .fd_data(b_fd_data), .rs_reset(b_rs_reset),
      .rs_incr(b_rs_incr), .rs_strobe(b_rs_strobe), .busy(b_busy), .done(b_done), .err(b_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic sb_compare(input logic [7:0] got);
      logic [7:0] e;
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else                 e = EV_EMPTY;
      chk("sb_event", 32'(got), 32'(e));
   endtask

   task automatic push_byte(input logic [7:0] b, input bit frame_end);
      for (int k = 0; k < 8; k++) sb_q.push_back({7'd0, b[k]});
      if (frame_end) begin
         sb_q.push_back(EV_STROBE);
         sb_q.push_back(EV_INCR);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the handshake edge.
   task automatic send_byte(input logic [7:0] b, input bit rnd);
      int guard;
      if (rnd) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge config_clk);
      end
      in_data  = b;
      in_valid = 1'b1;
      guard    = 0;
      while (in_ready !== 1'b1 && guard < 100) begin
         @(negedge config_clk);
         guard++;
      end
      if (guard >= 100) chk("hs_timeout", 32'd0, 32'd1);
      @(negedge config_clk);
      in_valid = 1'b0;
   endtask

   task automatic send_big(input logic [7:0] b);
      int guard;
      b_in_data  = b;
      b_in_valid = 1'b1;
      guard      = 0;
      while (b_in_ready !== 1'b1 && guard < 100) begin
         @(negedge config_clk);
         guard++;
      end
      if (guard >= 100) chk("big_hs_timeout", 32'd0, 32'd1);
      @(negedge config_clk);
      b_in_valid = 1'b0;
   endtask

   task automatic wait_done(input bit exp_err);
      int guard = 0;
      while (done !== 1'b1 && guard < 500) begin
         @(negedge config_clk);
         guard++;
      end
      chk("done", 32'(done), 32'd1);
      chk("busy_end", 32'(busy), 32'd0);
      chk("err", 32'(err), 32'(exp_err));
      chk("rdy_hunt", 32'(in_ready), 32'd1);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic run_load(input bit rnd, input bit dbl_fa, input bit bad_trailer);
      logic [7:0] b;
      logic [7:0] xacc;
      xacc = 8'd0;
      sb_q.push_back(EV_RESET);
      send_byte(8'hFA, rnd);
      if (dbl_fa) send_byte(8'hFA, rnd);
      send_byte(8'hB0, rnd);
      chk("busy_load", 32'(busy), 32'd1);
      chk("done_clr", 32'(done), 32'd0);
      for (int i = 0; i < 6; i++) begin
         b = 8'(i + 1);
         xacc = xacc ^ b;
         push_byte(b, (i % 2) == 1);
         send_byte(b, rnd);
      end
`ifdef CONFIG_LOADER_CHK_EN
      send_byte(bad_trailer ? 8'h00 : xacc, rnd);
      wait_done(bad_trailer);
`else
      wait_done(1'b0);
`endif
   endtask

   assign mon_code = rs_reset  ? EV_RESET  :
                     rs_strobe ? EV_STROBE :
                     rs_incr   ? EV_INCR   :
                     fd_shift  ? {7'd0, fd_data} : EV_NONE;

   // Small-instance monitor: every frame-port event is matched against the scoreboard.
   always @(negedge config_clk) begin
      if (config_rst_n) begin
         if (mon_code != EV_NONE) sb_compare(mon_code);
         if (fd_shift || rs_strobe || rs_incr) chk("rdy_low", 32'(in_ready), 32'd0);
         if (rs_strobe) chk("strobe_incr", 32'(rs_incr), 32'd0);
      end
   end

   // Big-instance monitor: bits shifted per frame and frame count.
   always @(negedge config_clk) begin
      if (b_rs_strobe) begin
         chk("big_frame_bits", 32'(big_shift), 32'd192);
         big_shift   <= 0;
         big_strobes <= big_strobes + 1;
      end else if (b_fd_shift) begin
         big_shift <= big_shift + 1;
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] bx;
      int guard;
      repeat (2) @(negedge config_clk);
      chk("rst_outs", 32'({in_ready, fd_shift, fd_data, rs_reset, rs_incr, rs_strobe, busy, done, err}), 32'd0);
      chk("big_rst_outs", 32'({b_in_ready, b_fd_shift, b_rs_strobe, b_busy, b_done, b_err}), 32'd0);
      config_rst_n = 1'b1;
      #1;
      chk("rdy_pre_edge", 32'(in_ready), 32'd0);
      @(negedge config_clk);
      chk("rdy_after_release", 32'(in_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);

      run_load(1'b0, 1'b0, 1'b0);
      run_load(1'b0, 1'b1, 1'b0);

      send_byte(8'hFA, 1'b0);
      send_byte(8'h12, 1'b0);
      send_byte(8'hB0, 1'b0);
      repeat (4) @(negedge config_clk);
      chk("nosync_rdy", 32'(in_ready), 32'd1);
      chk("nosync_busy", 32'(busy), 32'd0);
      chk("done_hold", 32'(done), 32'd1);

      run_load(1'b1, 1'b0, 1'b0);
`ifdef CONFIG_LOADER_CHK_EN
      run_load(1'b0, 1'b0, 1'b1);
      run_load(1'b0, 1'b0, 1'b0);
`endif

      // Reset right after the second frame's strobe.
      sb_q.push_back(EV_RESET);
      send_byte(8'hFA, 1'b0);
      send_byte(8'hB0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         push_byte(8'(i + 1), i == 1);
         send_byte(8'(i + 1), 1'b0);
      end
      sb_q.push_back(EV_STROBE);
      guard = 0;
      while (rs_strobe !== 1'b1 && guard < 100) begin
         @(negedge config_clk);
         guard++;
      end
      chk("strobe1_seen", 32'(rs_strobe), 32'd1);
      #2;
      config_rst_n = 1'b0;
      #1;
      chk("rst_async_outs", 32'({in_ready, fd_shift, fd_data, rs_reset, rs_incr, rs_strobe, busy, done, err}), 32'd0);
      chk("rst_sb_drained", 32'(sb_q.size()), 32'd0);
      repeat (3) @(negedge config_clk);
      config_rst_n = 1'b1;
      #1;
      chk("rdy_pre_edge2", 32'(in_ready), 32'd0);
      repeat (20) @(negedge config_clk);
      chk("idle_after_rst", 32'({busy, done}), 32'd0);
      run_load(1'b0, 1'b0, 1'b0);

      // Full-length stream on the default-parameter instance.
      bx = 8'd0;
      send_big(8'hFA);
      send_big(8'hB0);
      for (int i = 0; i < 288 * 24; i++) begin
         bx = bx ^ 8'(i);
         send_big(8'(i));
      end
`ifdef CONFIG_LOADER_CHK_EN
      send_big(bx);
`endif
      guard = 0;
      while (b_done !== 1'b1 && guard < 200) begin
         @(negedge config_clk);
         guard++;
      end
      chk("big_done", 32'(b_done), 32'd1);
      chk("big_busy", 32'(b_busy), 32'd0);
      chk("big_err", 32'(b_err), 32'd0);
      chk("big_strobes", 32'(big_strobes), 32'd288);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
